// File: rtl/alien_wave_controller_pkg.sv
// Shared formation constants, game-state encoding and the march-period helper
// used by the alien wave controller and the game state machine.
package alien_wave_controller_pkg;

    typedef enum logic [1:0] {
        START_SCREEN    = 2'd0,
        NEXT_LEVEL      = 2'd1,
        PLAY_GAME       = 2'd2,
        GAMEOVER_SCREEN = 2'd3
    } game_state_t;

    localparam int NUM_COLS    = 8;
    localparam int NUM_ROWS    = 4;
    localparam int NUM_ALIENS  = NUM_COLS * NUM_ROWS;
    localparam int ALIEN_IDX_W = $clog2(NUM_ALIENS);

    // Frames per step for a round: base minus per-round decrement, floored at 0, then at min_p.
    function automatic logic [7:0] calc_period(input logic [4:0] rnd, input int base,
                                               input int dec, input int min_p);
        logic [7:0] drop;
        logic [7:0] raw;
        drop = 8'(rnd) * 8'(dec);
        raw  = (8'(base) > drop) ? 8'(base) - drop : 8'd0;
        return (raw < 8'(min_p)) ? 8'(min_p) : raw;
    endfunction

endpackage

// File: rtl/alien_wave_controller_step_timer.sv
// Frame divider for the formation march: emits step_en on the fsync that
// completes one period of frames.
module alien_step_timer (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] period,
    output logic       step_en
);

    logic [7:0] frame_cnt;

    assign step_en = tick && (frame_cnt == period - 8'd1);

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst)
            frame_cnt <= 8'd0;
        else if (clear)
            frame_cnt <= 8'd0;
        else if (tick)
            frame_cnt <= step_en ? 8'd0 : frame_cnt + 8'd1;
    end

endmodule

// File: rtl/alien_wave_controller.sv
// Alien formation owner: alive mask, march position/direction, kill handling
// and the cleared/landed indications fed back to the game state machine.
module alien_wave_controller
    import alien_wave_controller_pkg::*;
#(
    parameter int X_START     = 64,
    parameter int Y_START     = 48,
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 368,
    parameter int STEP_X      = 8,
    parameter int STEP_Y      = 16,
    parameter int FORM_H      = 128,
    parameter int LAND_Y      = 416,
    parameter int BASE_PERIOD = 32,
    parameter int PERIOD_DEC  = 2,
    parameter int MIN_PERIOD  = 4
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    input  logic                   fsync,
    input  logic [1:0]             game_state,
    input  logic [4:0]             round,
    input  logic                   hit_valid,
    input  logic [ALIEN_IDX_W-1:0] hit_index,
    output logic [NUM_ALIENS-1:0]  alive_mask,
    output logic [ALIEN_IDX_W:0]   aliens_remaining,
    output logic                   all_aliens_dead,
    output logic                   aliens_landed,
    output logic [9:0]             form_x,
    output logic [9:0]             form_y,
    output logic                   kill_pulse
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_MARCH   = 2'd2;
    localparam logic [1:0] S_CLEARED = 2'd3;

    logic [1:0] state;
    logic [1:0] prev_gs;
    logic       dir_left;
    logic [7:0] period;

    logic       load_trig, exit_req, move_ok, hit_ok, step_en, land_nxt;
    logic [9:0] x_nxt, y_nxt;
    logic       dir_nxt;

    assign load_trig = (game_state == NEXT_LEVEL) && (prev_gs != NEXT_LEVEL);
    assign exit_req  = ((game_state == START_SCREEN) || (game_state == GAMEOVER_SCREEN)) &&
                       ((state == S_MARCH) || (state == S_CLEARED));
    assign move_ok   = (state == S_MARCH) && fsync && (game_state == PLAY_GAME) && !aliens_landed;
    assign hit_ok    = (state == S_MARCH) && hit_valid && (int'(hit_index) < NUM_ALIENS) &&
                       alive_mask[hit_index];

    alien_step_timer u_step_timer (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .clear     (load_trig),
        .tick      (move_ok),
        .period    (period),
        .step_en   (step_en)
    );

    // At an edge the formation drops a row and reverses instead of moving sideways.
    always_comb begin
        x_nxt   = form_x;
        y_nxt   = form_y;
        dir_nxt = dir_left;
        if (step_en) begin
            if (!dir_left) begin
                if ({1'b0, form_x} + 11'(STEP_X) > 11'(X_MAX)) begin
                    y_nxt   = form_y + 10'(STEP_Y);
                    dir_nxt = 1'b1;
                end else begin
                    x_nxt = form_x + 10'(STEP_X);
                end
            end else begin
                if ({1'b0, form_x} < 11'(X_MIN + STEP_X)) begin
                    y_nxt   = form_y + 10'(STEP_Y);
                    dir_nxt = 1'b0;
                end else begin
                    x_nxt = form_x - 10'(STEP_X);
                end
            end
        end
    end

    assign land_nxt = ({1'b0, y_nxt} + 11'(FORM_H)) >= 11'(LAND_Y);

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            prev_gs          <= START_SCREEN;
            dir_left         <= 1'b0;
            period           <= 8'(BASE_PERIOD);
            alive_mask       <= '0;
            aliens_remaining <= '0;
            all_aliens_dead  <= 1'b0;
            aliens_landed    <= 1'b0;
            form_x           <= 10'(X_START);
            form_y           <= 10'(Y_START);
            kill_pulse       <= 1'b0;
        end else begin
            prev_gs    <= game_state;
            kill_pulse <= 1'b0;
            if (load_trig) begin
                state            <= S_LOAD;
                alive_mask       <= '1;
                aliens_remaining <= (ALIEN_IDX_W+1)'(NUM_ALIENS);
                form_x           <= 10'(X_START);
                form_y           <= 10'(Y_START);
                dir_left         <= 1'b0;
                all_aliens_dead  <= 1'b0;
                aliens_landed    <= 1'b0;
                period           <= calc_period(round, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);
            end else if (exit_req) begin
                state            <= S_IDLE;
                alive_mask       <= '0;
                aliens_remaining <= '0;
                all_aliens_dead  <= 1'b0;
                aliens_landed    <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: state <= S_MARCH;
                    S_MARCH: begin
                        form_x   <= x_nxt;
                        form_y   <= y_nxt;
                        dir_left <= dir_nxt;
                        if (hit_ok) begin
                            alive_mask[hit_index] <= 1'b0;
                            aliens_remaining      <= aliens_remaining - 1'b1;
                            kill_pulse            <= 1'b1;
                        end
                        // Clearing the wave outranks a landing on the same step.
                        if (hit_ok && aliens_remaining == 1) begin
                            state           <= S_CLEARED;
                            all_aliens_dead <= 1'b1;
                        end else if (step_en && land_nxt) begin
                            aliens_landed <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assert property (@(posedge pixel_clk) (X_MAX + STEP_X) < 1024);

endmodule

// File: tb/tb_alien_wave_controller.sv
// Scoreboard bench for alien_wave_controller: a frame-level reference model
// predicts every cycle's outputs, a monitor compares them after each edge.
module tb_alien_wave_controller;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic        fsync;
    logic [1:0]  game_state;
    logic [4:0]  round;
    logic        hit_valid;
    logic [4:0]  hit_index;
    logic [31:0] alive_mask;
    logic [5:0]  aliens_remaining;
    logic        all_aliens_dead, aliens_landed, kill_pulse;
    logic [9:0]  form_x, form_y;

    alien_wave_controller dut (
        .pixel_clk        (pixel_clk),
        .rst              (rst),
        .fsync            (fsync),
        .game_state       (game_state),
        .round            (round),
        .hit_valid        (hit_valid),
        .hit_index        (hit_index),
        .alive_mask       (alive_mask),
        .aliens_remaining (aliens_remaining),
        .all_aliens_dead  (all_aliens_dead),
        .aliens_landed    (aliens_landed),
        .form_x           (form_x),
        .form_y           (form_y),
        .kill_pulse       (kill_pulse)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [31:0] alive;
        logic [5:0]  rem;
        logic        dead;
        logic        landed;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        kill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 idle, 1 loading, 2 marching, 3 wave cleared.
    int          m_mode, m_x, m_y, m_dir, m_fc, m_period;
    logic [31:0] m_alive;
    logic        m_landed, m_dead, m_kill;
    logic [1:0]  m_prev;
    logic [4:0]  cur_round;
    int          xf, it, r;
    logic [1:0]  g;
    int          idx[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_alive = '0; m_x = 64; m_y = 48; m_dir = 1; m_fc = 0; m_period = 32;
        m_landed = 0; m_dead = 0; m_kill = 0; m_prev = 2'd0;
    endtask

    task automatic model_step(input logic f, input logic [1:0] gs, input int rnd,
                              input logic hv, input logic [4:0] hi);
        bit stepped;
        stepped = 0;
        m_kill  = 0;
        if (gs == 2'd1 && m_prev != 2'd1) begin
            m_mode = 1; m_alive = '1; m_x = 64; m_y = 48; m_dir = 1; m_fc = 0;
            m_dead = 0; m_landed = 0;
            m_period = 32 - 2 * rnd;
            if (m_period < 4) m_period = 4;
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if ((m_mode == 2 || m_mode == 3) && (gs == 2'd0 || gs == 2'd3)) begin
            m_mode = 0; m_alive = '0; m_dead = 0; m_landed = 0;
        end else if (m_mode == 2) begin
            if (f && gs == 2'd2 && !m_landed) begin
                if (m_fc == m_period - 1) begin m_fc = 0; stepped = 1; end
                else m_fc++;
            end
            if (stepped) begin
                if ((m_dir > 0 && m_x + 8 > 368) || (m_dir < 0 && m_x - 8 < 16)) begin
                    m_y += 16; m_dir = -m_dir;
                end else begin
                    m_x += 8 * m_dir;
                end
            end
            if (hv && m_alive[hi]) begin
                m_alive[hi] = 1'b0;
                m_kill = 1;
                if (m_alive == 0) begin m_mode = 3; m_dead = 1; end
            end
            if (m_mode == 2 && stepped && m_y + 128 >= 416) m_landed = 1;
        end
        m_prev = gs;
    endtask

    task automatic drive(input logic f, input logic [1:0] gs, input logic hv, input logic [4:0] hi);
        exp_t t;
        @(negedge pixel_clk);
        fsync = f; game_state = gs; round = cur_round; hit_valid = hv; hit_index = hi;
        model_step(f, gs, int'(cur_round), hv, hi);
        t.alive = m_alive; t.rem = 6'($countones(m_alive)); t.dead = m_dead;
        t.landed = m_landed; t.x = 10'(m_x); t.y = 10'(m_y); t.kill = m_kill;
        sb.push_back(t);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'd2, 1'b0, 5'd0);
            drive(1'b1, 2'd2, 1'b0, 5'd0);
        end
    endtask

    task automatic settle();
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mask"}, alive_mask, 32'h0);
        chk({tag, "_rem"}, aliens_remaining, 0);
        chk({tag, "_dead"}, all_aliens_dead, 0);
        chk({tag, "_landed"}, aliens_landed, 0);
        chk({tag, "_kill"}, kill_pulse, 0);
        chk({tag, "_x"}, form_x, 64);
        chk({tag, "_y"}, form_y, 48);
    endtask

    always @(posedge pixel_clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_mask", alive_mask, e.alive);
            chk("sb_rem", aliens_remaining, e.rem);
            chk("sb_dead", all_aliens_dead, e.dead);
            chk("sb_landed", aliens_landed, e.landed);
            chk("sb_x", form_x, e.x);
            chk("sb_y", form_y, e.y);
            chk("sb_kill", kill_pulse, e.kill);
        end
    end

    initial begin
        rst = 1'b1; fsync = 0; game_state = 2'd0; round = 0; hit_valid = 0; hit_index = 0;
        cur_round = 0;
        model_reset();
        #12;
        chk_reset("reset");
        @(negedge pixel_clk);
        rst = 1'b0;

        // Load, then a full round-0 period of 32 frames.
        drive(1'b0, 2'd0, 1'b0, 5'd0);
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        settle();
        chk("load_mask", alive_mask, 32'hFFFF_FFFF);
        chk("load_rem", aliens_remaining, 32);
        chk("load_x", form_x, 64);
        chk("load_y", form_y, 48);
        chk("load_dead", all_aliens_dead, 0);
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        play(31);
        settle();
        chk("r0_31fs_x", form_x, 64);
        play(1);
        settle();
        chk("r0_32fs_x", form_x, 72);

        // Repeated hit on one alien counts once.
        drive(1'b0, 2'd2, 1'b1, 5'd5);
        settle();
        chk("hit5_kill", kill_pulse, 1);
        chk("hit5_bit", alive_mask[5], 0);
        chk("hit5_rem", aliens_remaining, 31);
        drive(1'b0, 2'd2, 1'b1, 5'd5);
        settle();
        chk("hit5_again_kill", kill_pulse, 0);
        chk("hit5_again_rem", aliens_remaining, 31);

        // Round 20: period clamps to 4.
        cur_round = 5'd20;
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        play(3);  settle(); chk("r20_3fs_x", form_x, 64);
        play(1);  settle(); chk("r20_4fs_x", form_x, 72);
        play(3);  settle(); chk("r20_7fs_x", form_x, 72);
        play(1);  settle(); chk("r20_8fs_x", form_x, 80);

        // Right edge: drop and reverse, then step left.
        for (int k = 0; k < 400 && m_x != 368; k++) play(1);
        settle();
        chk("edge_reach_x", form_x, 368);
        play(4); settle();
        chk("edge_drop_y", form_y, 64);
        chk("edge_drop_x", form_x, 368);
        play(4); settle();
        chk("edge_left_x", form_x, 360);

        // March down until landing, with sparse random hits.
        it = 0;
        while (!m_landed && it < 4000) begin
            drive(1'b1, 2'd2, ($urandom_range(0, 199) == 0), 5'($urandom_range(0, 31)));
            drive(1'b0, 2'd2, 1'b0, 5'd0);
            it++;
        end
        settle();
        chk("landed", aliens_landed, 1);
        chk("landed_y", form_y, 288);
        xf = m_x;
        play(8); settle();
        chk("landed_frozen_x", form_x, 32'(xf));
        chk("landed_frozen_y", form_y, 288);

        drive(1'b0, 2'd3, 1'b0, 5'd0);
        settle();
        chk("idle_mask", alive_mask, 0);
        chk("idle_landed", aliens_landed, 0);
        chk("idle_rem", aliens_remaining, 0);

        // Kill the whole wave in random order.
        cur_round = 5'd5;
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        drive(1'b0, 2'd1, 1'b1, 5'd0);
        settle();
        chk("load_hit_kill", kill_pulse, 0);
        chk("load_hit_rem", aliens_remaining, 32);
        for (int i = 0; i < 32; i++) idx[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 32; i++) drive((i % 3) == 0, 2'd2, 1'b1, 5'(idx[i]));
        settle();
        chk("clear_dead", all_aliens_dead, 1);
        chk("clear_rem", aliens_remaining, 0);
        xf = m_x;
        drive(1'b0, 2'd2, 1'b1, 5'd3);
        settle();
        chk("clear_hit_kill", kill_pulse, 0);
        play(40); settle();
        chk("clear_frozen_x", form_x, 32'(xf));
        chk("clear_still_dead", all_aliens_dead, 1);

        // Reload from CLEARED at round 1: period 30.
        cur_round = 5'd1;
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        drive(1'b0, 2'd1, 1'b0, 5'd0);
        settle();
        chk("r1_dead", all_aliens_dead, 0);
        chk("r1_rem", aliens_remaining, 32);
        play(29); settle(); chk("r1_29fs_x", form_x, 64);
        play(1);  settle(); chk("r1_30fs_x", form_x, 72);

        // Asynchronous reset mid-march.
        @(posedge pixel_clk);
        #3 rst = 1'b1;
        #1 chk_reset("midrst");
        model_reset();
        fsync = 0; game_state = 2'd0; hit_valid = 0;
        repeat (2) @(negedge pixel_clk);
        rst = 1'b0;

        // Random play: state changes, rounds, frames and hits.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            g = (r < 1) ? 2'd0 : (r < 2) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
            if ($urandom_range(0, 49) == 0) cur_round = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), g, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
        end

        repeat (3) @(posedge pixel_clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
